pb_irq_ctrl: RTL
================

Name: pb_irq_ctrl

Overview:
Interrupt controller that merges up to 8 level-sensitive interrupt sources into the single PicoBlaze interrupt/interrupt_ack pair. Sources are typically the int_out outputs of input-port IOC blocks. A round-robin arbiter selects one unmasked pending source. The controller presents its vector number on a readable I/O port and holds off further interrupts until firmware writes an end-of-interrupt (EOI) port. It sits on the processor port bus beside the other I/O ports, and its port_out feeds the input-port selector mux.

Parameters:
ADDR_MASK, 8'h10, port address of the mask register (read/write)
ADDR_VEC, 8'h11, port address of the vector/status register (read-only)
ADDR_EOI, 8'h12, port address of the EOI strobe (write-only, data ignored)
NSRC, 4, number of interrupt sources; legal range 1..8

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
address  in  8  processor port_id
value_in  in  8  processor out_port data
wen  in  1  processor write_strobe
ren  in  1  processor read_strobe; no effect on state
irq_src  in  NSRC  level interrupt requests, already synchronous to clk
port_out  out  8  registered read data for the input-port selector
interrupt  out  1  to PicoBlaze interrupt input
interrupt_ack  in  1  from PicoBlaze interrupt_ack
src_ack  out  NSRC  one-hot, one-cycle pulse to the granted source (clears its flag)
in_service  out  1  high from grant until EOI

Behaviour:
- Reset values (async): mask=0 (all disabled), state=IDLE, vec=0, last=NSRC-1, interrupt=0, src_ack=0, in_service=0, port_out=0.
- Mask write: wen && address==ADDR_MASK -> mask <= value_in[NSRC-1:0]. The write takes effect the next cycle. Arbitration in the write cycle uses the old mask.
- pending = irq_src & mask, evaluated combinationally each cycle.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE, pending != 0: grant the first set bit of pending, searching upward from (last+1) mod NSRC with wrap. Set vec <= grant, interrupt <= 1, in_service <= 1, go to REQ. Latency is 1 clock from the edge where pending is seen to interrupt high.
  - IDLE, pending == 0: stay in IDLE.
  - REQ: hold interrupt=1 until interrupt_ack is sampled high. On that edge: interrupt <= 0, src_ack[vec] <= 1 for exactly one cycle, go to SERVICE.
  - REQ boundary cases: deassertion of irq_src or a mask change does not cancel the request, and vec stays as granted. An EOI write is ignored.
  - SERVICE: wait for wen && address==ADDR_EOI. On that edge: last <= vec, in_service <= 0, go to IDLE.
  - SERVICE boundary cases: new pending requests are held off. interrupt_ack is ignored.
- After EOI, IDLE lasts at least one cycle before the next grant. Back-to-back interrupts are therefore separated by at least 1 cycle of interrupt=0.
- Round-robin: the most recently serviced source has the lowest priority for the next arbitration. After reset, source 0 has the highest priority.
- Read path, updated every clock regardless of ren:
  - address==ADDR_VEC: port_out <= {in_service, 4'b0, vec[2:0]}
  - address==ADDR_MASK: port_out <= mask zero-extended
  - any other address: port_out <= 0
  - Reads have no side effects.
- Width rules: vec is 3 bits. Unused mask bits above NSRC read as 0, and writes to them are discarded.
- Simultaneous mask write and EOI are impossible (single address). A simultaneous EOI write and new irq_src assertion follows the normal path: grant on the next IDLE cycle.
- Reset asserted mid-operation (any state) returns everything to reset values immediately, and any src_ack pulse in progress is truncated. Resets are independent: the sources are not notified.

Test Plan:
- Reset then mask=0x0F, irq_src=4'b0100 -> interrupt high 1 cycle later; a read of ADDR_VEC returns 8'h82. interrupt_ack pulse -> interrupt low, src_ack=4'b0100 for exactly 1 cycle. EOI write -> in_service=0, a read of ADDR_VEC returns 8'h02.
- mask=0x0F, irq_src=4'b1111 held, firmware acks and sends EOI each time -> grant sequence 0,1,2,3,0 (round-robin wrap).
- mask=0x05, irq_src=4'b0010 -> interrupt stays 0. Write mask=0x07 -> interrupt rises 1 cycle after the write takes effect, vec=1.
- irq_src=4'b0001 granted, then irq_src=0 before interrupt_ack -> interrupt held until ack, vec=0, src_ack=4'b0001. An EOI written during REQ is ignored (state stays REQ).
- Raise irq_src[3] during SERVICE of source 1 -> no interrupt until EOI. After EOI there is at least 1 cycle with interrupt=0, then vec=3.
- Assert rst mid-REQ -> interrupt=0, mask=0, in_service=0, port_out=0 asynchronously. After release with mask=0x0F and irq_src=4'b1010, vec=1 (source 0 has top priority post-reset).

Source files
------------

// File: rtl/pb_irq_ctrl.sv
// PicoBlaze interrupt controller: round-robin merge of NSRC level requests into interrupt/interrupt_ack,
// with a mask port, a vector/status read port and an end-of-interrupt strobe port.
`timescale 1ns/1ps
module pb_irq_ctrl #(
  parameter logic [7:0] ADDR_MASK = 8'h10,
  parameter logic [7:0] ADDR_VEC  = 8'h11,
  parameter logic [7:0] ADDR_EOI  = 8'h12,
  parameter int         NSRC      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      address,
  input  logic [7:0]      value_in,
  input  logic            wen,
  input  logic            ren,
  input  logic [NSRC-1:0] irq_src,
  output logic [7:0]      port_out,
  output logic            interrupt,
  input  logic            interrupt_ack,
  output logic [NSRC-1:0] src_ack,
  output logic            in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [2:0]      vec, vec_nxt;
  logic [2:0]      last, last_nxt;
  logic            irq_nxt, svc_nxt;
  logic [NSRC-1:0] ack_nxt;
  logic [2:0]      grant, grant_hi, grant_lo;
  logic            found_hi;
  logic            eoi;
  logic [7:0]      mask_ext;
  logic [7:0]      rd_nxt;
  logic            unused;

  // Reads are side-effect free, so the strobe and the data bits above NSRC carry no meaning here.
  assign unused  = ren ^ (^value_in);
  assign pending = irq_src & mask;
  assign eoi     = wen && (address == ADDR_EOI);

  // Round-robin: lowest pending index above last wins, else wrap to lowest pending overall.
  always_comb begin
    found_hi = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int j = NSRC - 1; j >= 0; j--) begin
      if (pending[j]) begin
        grant_lo = 3'(j);
        if (3'(j) > last) begin
          grant_hi = 3'(j);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    last_nxt  = last;
    irq_nxt   = interrupt;
    svc_nxt   = in_service;
    ack_nxt   = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          vec_nxt   = grant;
          irq_nxt   = 1'b1;
          svc_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          irq_nxt = 1'b0;
          for (int i = 0; i < NSRC; i++) begin
            if (vec == 3'(i)) ack_nxt[i] = 1'b1;
          end
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          last_nxt  = vec;
          svc_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mask_ext           = '0;
    mask_ext[NSRC-1:0] = mask;
    case (address)
      ADDR_VEC:  rd_nxt = {in_service, 4'b0000, vec};
      ADDR_MASK: rd_nxt = mask_ext;
      default:   rd_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mask       <= '0;
      vec        <= '0;
      last       <= 3'(NSRC - 1);
      interrupt  <= 1'b0;
      src_ack    <= '0;
      in_service <= 1'b0;
      port_out   <= 8'h00;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      last       <= last_nxt;
      interrupt  <= irq_nxt;
      src_ack    <= ack_nxt;
      in_service <= svc_nxt;
      port_out   <= rd_nxt;
      if (wen && (address == ADDR_MASK)) mask <= value_in[NSRC-1:0];
    end
  end

endmodule
